issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 The block SHALL have parameter MULDIV_LAT, default 4, giving the cycles one mul/div op occupies the iterative unit (legal range 2..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port cand  input  ex_content_t[2]  issue candidates from wakeup; slot 0 is the older entry (higher tag).
REQ-005 The block SHALL have port flush  input  1  branch-mispredict squash.
REQ-006 The block SHALL have port grant  output  1[2]  slot i was accepted this cycle; the buffer marks that entry executing.
REQ-007 The block SHALL have ports alu_out[2], muldiv_out, lsu_out  output  ex_content_t  registered dispatch per unit; .is_valid qualifies each.
REQ-008 The block SHALL have ports lsu_req_ready and lsu_resp_valid  input  1  memory-port handshake.

Function
REQ-009 Unit classes SHALL be: ALU and BRANCH -> ALU class; MUL and DIV -> MULDIV class; LOAD and STORE -> LSU class; EX_GEN_ADDR candidates arrive as ALU and SHALL go to the ALU class.
REQ-010 grant SHALL be combinational from cand, flush and current state, with zero latency.
REQ-011 ALU class SHALL always be grantable: with one ALU request, it uses alu_out[0]; with two, slot 0 uses alu_out[0] and slot 1 uses alu_out[1].
REQ-012 MULDIV SHALL be granted only when busy counter == 0; at most one per cycle, slot 0 first.
REQ-013 On a MULDIV grant, the counter SHALL load MULDIV_LAT-1 and then decrement once per cycle down to 0, so grants are at least MULDIV_LAT cycles apart.
REQ-014 LSU FSM SHALL have the states IDLE, REQ and WAIT. IDLE goes to REQ on grant. REQ goes to WAIT when lsu_req_ready=1. WAIT goes to IDLE when lsu_resp_valid=1.
REQ-015 An LSU grant SHALL be possible only in IDLE; at most one per cycle, slot 0 first.
REQ-016 lsu_out.is_valid SHALL be held high for the whole REQ state, with its contents stable until lsu_req_ready is seen.
REQ-017 A slot whose class is unavailable, or loses same-class arbitration, SHALL get grant=0 and stays in the buffer, to reappear next cycle.
REQ-018 Slot 1 SHALL be granted independently of slot 0 when its class differs; for example, slot 0 MUL blocked plus slot 1 ALU means only slot 1 is granted.
REQ-019 Each granted candidate SHALL appear on its unit port exactly one cycle after grant, with all fields copied unchanged.
REQ-020 alu_out and muldiv_out valid SHALL be single-cycle pulses.
REQ-021 A candidate with is_valid=0 SHALL never be granted.
REQ-022 While flush=1, both grants SHALL be 0.
REQ-023 While flush=1, the next cycle's alu_out and muldiv_out valid SHALL be 0.
REQ-024 While flush=1, the MULDIV counter SHALL clear to 0.
REQ-025 Flush in REQ SHALL return the LSU FSM to IDLE, dropping lsu_out.is_valid.
REQ-026 Flush in WAIT SHALL keep the LSU FSM in WAIT until lsu_resp_valid, so the outstanding response drains.
REQ-027 When lsu_resp_valid and a new LSU candidate coincide in WAIT, the candidate SHALL NOT be granted; grant is possible from the next cycle, in IDLE.
REQ-028 lsu_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-029 On rst_n=0, asynchronously: all *_out.is_valid = 0, all *_out fields = 0, MULDIV counter = 0, LSU FSM = IDLE, grant = 0.
REQ-030 Reset asserted mid-operation (counter nonzero, or FSM in REQ/WAIT) SHALL abandon the operation with no residual state.
REQ-031 The first grant after reset SHALL be possible in the first cycle with rst_n=1.

Structure
REQ-032 unit_t, ex_mode_t, ex_content_t and a new lsu_state_t enum SHALL live in the shared package.
REQ-033 MULDIV_LAT SHALL be a module parameter defaulting to a package constant.
REQ-034 One sub-module, lsu_port_fsm, SHALL hold the LSU state machine and lsu_out register.
REQ-035 Class decode and arbitration SHALL stay in the top module.

Verification
REQ-036 Two ALU candidates with tags 9 and 5: grant=11, then next cycle alu_out[0].tag=9 and alu_out[1].tag=5.
REQ-037 MUL on slot 0 every cycle with MULDIV_LAT=4: grants at cycles 0, 4, 8; muldiv_out valid at cycles 1, 5, 9.
REQ-038 Slot 0 DIV while busy, slot 1 ALU tag 3: grant=01; alu_out[0].tag=3 next cycle.
REQ-039 LOAD granted with lsu_req_ready held 0 for 3 cycles: lsu_out valid and stable for 3 cycles, then WAIT; resp_valid at cycle 6 returns to IDLE; STORE candidate granted at cycle 7.
REQ-040 Flush in REQ with MULDIV counter=2: grants=0 that cycle, LSU IDLE, counter 0 next cycle, and a MUL is grantable immediately after the flush.
REQ-041 rst_n pulled low with the LSU FSM in WAIT and counter=3: all outputs 0 asynchronously, and after release a LOAD is granted in the first cycle.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: candidate payload, unit/mode encodings,
// LSU port states and the execution-class decode used for arbitration.
package issue_scheduler_pkg;

  localparam int unsigned MULDIV_LAT_DEF = 4;
  localparam int unsigned MD_CNT_W       = 4;
  localparam int unsigned TAG_W          = 6;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_DIV    = 3'd3,
    UNIT_LOAD   = 3'd4,
    UNIT_STORE  = 3'd5
  } unit_t;

  typedef enum logic [1:0] {
    EX_NORMAL   = 2'd0,
    EX_GEN_ADDR = 2'd1,
    EX_SIGNED   = 2'd2,
    EX_UNSIGNED = 2'd3
  } ex_mode_t;

  typedef struct packed {
    logic             is_valid;
    logic [TAG_W-1:0] tag;
    unit_t            unit;
    ex_mode_t         mode;
    logic [4:0]       rd;
    logic [31:0]      imm;
  } ex_content_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_MULDIV = 2'd1,
    CLS_LSU    = 2'd2
  } ex_class_t;

  // Address generation is tagged as ALU upstream, so it falls into the ALU class.
  function automatic ex_class_t unit_class(input unit_t u);
    case (u)
      UNIT_ALU, UNIT_BRANCH: unit_class = CLS_ALU;
      UNIT_MUL, UNIT_DIV:    unit_class = CLS_MULDIV;
      UNIT_LOAD, UNIT_STORE: unit_class = CLS_LSU;
      default:               unit_class = CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/issue_scheduler_lsu_port_fsm.sv
// LSU dispatch port: holds one request on lsu_out until the memory port accepts it,
// then waits for the response before allowing another grant.
module lsu_port_fsm
  import issue_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        i_go,
  input  ex_content_t i_cand,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        o_idle,
  output ex_content_t lsu_out
);

  lsu_state_t  r_state;
  ex_content_t r_lsu_out;

  // Port state machine; a flush only cancels a request that memory has not yet taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LSU_IDLE;
      r_lsu_out <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (i_go) begin
            r_state   <= LSU_REQ;
            r_lsu_out <= i_cand;
          end else begin
            r_state   <= LSU_IDLE;
            r_lsu_out <= '0;
          end
        end
        LSU_REQ: begin
          if (flush) begin
            r_state   <= LSU_IDLE;
            r_lsu_out <= '0;
          end else if (lsu_req_ready) begin
            r_state   <= LSU_WAIT;
            r_lsu_out <= '0;
          end else begin
            r_state   <= LSU_REQ;
            r_lsu_out <= r_lsu_out;
          end
        end
        LSU_WAIT: begin
          r_lsu_out <= '0;
          if (lsu_resp_valid) begin
            r_state <= LSU_IDLE;
          end else begin
            r_state <= LSU_WAIT;
          end
        end
        default: begin
          r_state   <= LSU_IDLE;
          r_lsu_out <= '0;
        end
      endcase
    end
  end

  assign o_idle  = (r_state == LSU_IDLE);
  assign lsu_out = r_lsu_out;

endmodule

// File: rtl/issue_scheduler.sv
// Two-wide issue scheduler: decodes candidate classes, arbitrates ALU / MULDIV / LSU
// resources with slot 0 priority and registers each dispatch onto its unit port.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_content_t cand [2],
  input  logic        flush,
  output logic        grant [2],
  output ex_content_t alu_out [2],
  output ex_content_t muldiv_out,
  output ex_content_t lsu_out,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid
);

  logic [MD_CNT_W-1:0] r_md_cnt;
  ex_content_t         r_alu_out [2];
  ex_content_t         r_muldiv_out;

  ex_class_t   w_cls0, w_cls1;
  logic        w_req0, w_req1, w_g0, w_g1;
  logic        w_md_free, w_lsu_idle;
  logic        w_alu_s0, w_alu_s1, w_md_s0, w_md_s1, w_lsu_s0, w_lsu_s1;
  logic        w_md_go, w_lsu_go;
  ex_content_t w_alu0_nxt, w_alu1_nxt, w_md_nxt, w_lsu_cand;

  assign w_cls0    = unit_class(cand[0].unit);
  assign w_cls1    = unit_class(cand[1].unit);
  assign w_req0    = rst_n && !flush && cand[0].is_valid;
  assign w_req1    = rst_n && !flush && cand[1].is_valid;
  assign w_md_free = (r_md_cnt == {MD_CNT_W{1'b0}});

  // Per-slot grant; slot 1 only loses a shared resource to a slot 0 grant of the same class.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    case (w_cls0)
      CLS_ALU:    w_g0 = w_req0;
      CLS_MULDIV: w_g0 = w_req0 && w_md_free;
      CLS_LSU:    w_g0 = w_req0 && w_lsu_idle;
      default:    w_g0 = 1'b0;
    endcase
    case (w_cls1)
      CLS_ALU:    w_g1 = w_req1;
      CLS_MULDIV: w_g1 = w_req1 && w_md_free && !(w_g0 && (w_cls0 == CLS_MULDIV));
      CLS_LSU:    w_g1 = w_req1 && w_lsu_idle && !(w_g0 && (w_cls0 == CLS_LSU));
      default:    w_g1 = 1'b0;
    endcase
    grant[0] = w_g0;
    grant[1] = w_g1;
  end

  assign w_alu_s0 = w_g0 && (w_cls0 == CLS_ALU);
  assign w_alu_s1 = w_g1 && (w_cls1 == CLS_ALU);
  assign w_md_s0  = w_g0 && (w_cls0 == CLS_MULDIV);
  assign w_md_s1  = w_g1 && (w_cls1 == CLS_MULDIV);
  assign w_lsu_s0 = w_g0 && (w_cls0 == CLS_LSU);
  assign w_lsu_s1 = w_g1 && (w_cls1 == CLS_LSU);
  assign w_md_go  = w_md_s0 || w_md_s1;
  assign w_lsu_go = w_lsu_s0 || w_lsu_s1;

  // A lone ALU grant always lands on alu_out[0], whichever slot it came from.
  assign w_alu0_nxt = w_alu_s0 ? cand[0] : (w_alu_s1 ? cand[1] : '0);
  assign w_alu1_nxt = (w_alu_s0 && w_alu_s1) ? cand[1] : '0;
  assign w_md_nxt   = w_md_s0 ? cand[0] : (w_md_s1 ? cand[1] : '0);
  assign w_lsu_cand = w_lsu_s0 ? cand[0] : (w_lsu_s1 ? cand[1] : '0);

  // Busy counter spacing MULDIV grants MULDIV_LAT cycles apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= {MD_CNT_W{1'b0}};
    end else if (flush) begin
      r_md_cnt <= {MD_CNT_W{1'b0}};
    end else if (w_md_go) begin
      r_md_cnt <= MD_CNT_W'(MULDIV_LAT - 1);
    end else if (!w_md_free) begin
      r_md_cnt <= r_md_cnt - {{(MD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

  // Single-cycle dispatch registers for the ALU and MULDIV ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out[0] <= '0;
      r_alu_out[1] <= '0;
      r_muldiv_out <= '0;
    end else begin
      r_alu_out[0] <= w_alu0_nxt;
      r_alu_out[1] <= w_alu1_nxt;
      r_muldiv_out <= w_md_nxt;
    end
  end

  assign alu_out[0] = r_alu_out[0];
  assign alu_out[1] = r_alu_out[1];
  assign muldiv_out = r_muldiv_out;

  lsu_port_fsm u_lsu_port (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .i_go           (w_lsu_go),
    .i_cand         (w_lsu_cand),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .o_idle         (w_lsu_idle),
    .lsu_out        (lsu_out)
  );

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: expected dispatches are queued when a grant is
// expected and compared one cycle later on the unit ports.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic        clk;
  logic        rst_n;
  ex_content_t cand [2];
  logic        flush;
  logic        grant [2];
  ex_content_t alu_out [2];
  ex_content_t muldiv_out;
  ex_content_t lsu_out;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  ex_content_t q_alu0 [$];
  ex_content_t q_alu1 [$];
  ex_content_t q_md   [$];
  ex_content_t m_lsu;

  issue_scheduler #(.MULDIV_LAT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cand           (cand),
    .flush          (flush),
    .grant          (grant),
    .alu_out        (alu_out),
    .muldiv_out     (muldiv_out),
    .lsu_out        (lsu_out),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_content_t mk(input unit_t u, input logic [5:0] t);
    ex_content_t c;
    c          = '0;
    c.is_valid = 1'b1;
    c.tag      = t;
    c.unit     = u;
    c.mode     = ex_mode_t'(t[1:0]);
    c.rd       = t[4:0] ^ 5'h1f;
    c.imm      = {t, 26'h2b5a3c1};
    return c;
  endfunction

  function automatic logic is_alu(input unit_t u);
    return (u == UNIT_ALU) || (u == UNIT_BRANCH);
  endfunction
  function automatic logic is_md(input unit_t u);
    return (u == UNIT_MUL) || (u == UNIT_DIV);
  endfunction
  function automatic logic is_lsu(input unit_t u);
    return (u == UNIT_LOAD) || (u == UNIT_STORE);
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input ex_content_t obs, input ex_content_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_bit({tag, "_grant0"}, grant[0], 1'b0);
    chk_bit({tag, "_grant1"}, grant[1], 1'b0);
    chk_ex({tag, "_alu0"}, alu_out[0], '0);
    chk_ex({tag, "_alu1"}, alu_out[1], '0);
    chk_ex({tag, "_md"}, muldiv_out, '0);
    chk_ex({tag, "_lsu"}, lsu_out, '0);
  endtask

  // One cycle: check grants, queue expected dispatches, then check the unit ports.
  task automatic tick(input logic eg0, input logic eg1, input logic elv);
    ex_content_t ea0, ea1, em, el;
    #1;
    chk_bit("grant0", grant[0], eg0);
    chk_bit("grant1", grant[1], eg1);
    ea0 = '0;
    ea1 = '0;
    em  = '0;
    if (eg0 && is_alu(cand[0].unit)) ea0 = cand[0];
    if (eg1 && is_alu(cand[1].unit)) begin
      if (eg0 && is_alu(cand[0].unit)) ea1 = cand[1];
      else ea0 = cand[1];
    end
    if (eg0 && is_md(cand[0].unit)) em = cand[0];
    else if (eg1 && is_md(cand[1].unit)) em = cand[1];
    if (eg0 && is_lsu(cand[0].unit)) m_lsu = cand[0];
    else if (eg1 && is_lsu(cand[1].unit)) m_lsu = cand[1];
    q_alu0.push_back(ea0);
    q_alu1.push_back(ea1);
    q_md.push_back(em);
    @(posedge clk);
    #1;
    chk_ex("alu_out0", alu_out[0], q_alu0.pop_front());
    chk_ex("alu_out1", alu_out[1], q_alu1.pop_front());
    chk_ex("muldiv_out", muldiv_out, q_md.pop_front());
    el = elv ? m_lsu : '0;
    chk_ex("lsu_out", lsu_out, el);
  endtask

  initial begin
    m_lsu          = '0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    cand[0]        = mk(UNIT_LOAD, 6'd1);
    cand[1]        = mk(UNIT_ALU, 6'd2);
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two ALU candidates in the first cycle after reset.
    cand[0] = mk(UNIT_ALU, 6'd9);
    cand[1] = mk(UNIT_ALU, 6'd5);
    tick(1'b1, 1'b1, 1'b0);

    // Invalid candidates are never granted.
    cand[0] = mk(UNIT_ALU, 6'd4);
    cand[0].is_valid = 1'b0;
    cand[1] = mk(UNIT_BRANCH, 6'd6);
    cand[1].is_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Address generation and branch both use ALU ports.
    cand[0] = mk(UNIT_ALU, 6'd10);
    cand[0].mode = EX_GEN_ADDR;
    cand[1] = mk(UNIT_BRANCH, 6'd11);
    tick(1'b1, 1'b1, 1'b0);

    // MUL every cycle: grants at 0, 4, 8; a LOAD joins at cycle 8.
    for (int i = 0; i < 9; i++) begin
      cand[0] = mk(UNIT_MUL, 6'(16 + i));
      cand[1] = (i == 8) ? mk(UNIT_LOAD, 6'd30) : '0;
      tick((i % 4) == 0, i == 8, i == 8);
    end

    // DIV blocked by busy unit, ALU in slot 1 still goes; LOAD still in REQ.
    cand[0] = mk(UNIT_DIV, 6'd20);
    cand[1] = mk(UNIT_ALU, 6'd3);
    tick(1'b0, 1'b1, 1'b1);

    // Flush with LSU in REQ and counter at 2.
    flush   = 1'b1;
    cand[0] = mk(UNIT_MUL, 6'd21);
    cand[1] = mk(UNIT_ALU, 6'd22);
    tick(1'b0, 1'b0, 1'b0);
    flush   = 1'b0;
    cand[0] = mk(UNIT_MUL, 6'd23);
    cand[1] = mk(UNIT_LOAD, 6'd24);
    tick(1'b1, 1'b1, 1'b1);

    // LOAD held in REQ three cycles, STORE waits behind it.
    cand[0] = mk(UNIT_STORE, 6'd25);
    cand[1] = '0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    lsu_req_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    lsu_req_ready = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    lsu_resp_valid = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    lsu_resp_valid = 1'b0;
    tick(1'b1, 1'b0, 1'b1);

    // Flush in WAIT keeps waiting for the response.
    lsu_req_ready = 1'b1;
    cand[0] = mk(UNIT_LOAD, 6'd26);
    tick(1'b0, 1'b0, 1'b0);
    lsu_req_ready = 1'b0;
    flush = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    lsu_resp_valid = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Response strobes in IDLE and REQ are ignored.
    tick(1'b1, 1'b0, 1'b1);
    cand[0] = '0;
    tick(1'b0, 1'b0, 1'b1);
    lsu_resp_valid = 1'b0;

    // Enter WAIT with counter at 3, then reset asynchronously.
    lsu_req_ready = 1'b1;
    cand[0] = mk(UNIT_MUL, 6'd27);
    tick(1'b1, 1'b0, 1'b0);
    lsu_req_ready = 1'b0;
    cand[0] = mk(UNIT_LOAD, 6'd28);
    cand[1] = mk(UNIT_ALU, 6'd29);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    lsu_req_ready = 1'b1;
    cand[0] = mk(UNIT_MUL, 6'd31);
    cand[1] = '0;
    tick(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
